// File: rtl/sram_copy_pkg.sv
// Shared definitions for the SRAM block copier.
//   state_t   : transfer sequencer states
//   MODE_COPY : copy source SRAM run into destination SRAM
//   MODE_FILL : write a constant into a destination SRAM run
package sram_copy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/sram_block_copier.sv
// Block-transfer engine driving a source SRAM read port and a destination
// SRAM write port. Copies a run of words (1-cycle read latency) or fills a
// run with a constant, one word per enabled clock.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cen                   clock enable; low freezes all state and outputs
//   start, mode           request (taken in IDLE only) and copy/fill select
//   src_base, dst_base    first source / destination address
//   len                   word count, 0..2**ADDR_WIDTH
//   fill_value            constant written in fill mode
//   busy, done            transfer in progress / one-cycle completion pulse
//   SRC_ADDR, SRC_Q       source read address and its data (1 cycle later)
//   DST_ADDR, DST_DATA    destination write address and data
//   DST_WE, DST_CEN       destination write strobe and port enable
module sram_block_copier #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] SRC_ADDR,
  input  logic [DATA_WIDTH-1:0] SRC_Q,
  output logic [ADDR_WIDTH-1:0] DST_ADDR,
  output logic [DATA_WIDTH-1:0] DST_DATA,
  output logic                  DST_WE,
  output logic                  DST_CEN
);

  import sram_copy_pkg::*;

  state_t                  state;
  logic                    mode_q;
  logic [DATA_WIDTH-1:0]   fill_q;
  logic [ADDR_WIDTH:0]     remain;   // reads still to issue
  logic [ADDR_WIDTH-1:0]   wr_ptr;   // next destination address to present

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= MODE_COPY;
      fill_q   <= '0;
      remain   <= '0;
      wr_ptr   <= '0;
      SRC_ADDR <= '0;
      DST_ADDR <= '0;
      DST_WE   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (cen) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            fill_q <= fill_value;
            remain <= len;
            wr_ptr <= dst_base;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              SRC_ADDR <= src_base;
              state    <= RUN;
              busy     <= 1'b1;
            end
          end
        end
        // Each RUN cycle presents one read; the matching write goes out one
        // cycle later, when SRC_Q for that read is valid. The write pointer
        // therefore trails the read address by exactly one enabled cycle.
        RUN: begin
          SRC_ADDR <= SRC_ADDR + 1'b1;
          DST_ADDR <= wr_ptr;
          wr_ptr   <= wr_ptr + 1'b1;
          DST_WE   <= 1'b1;
          remain   <= remain - 1'b1;
          if (remain == (ADDR_WIDTH+1)'(1))
            state <= DRAIN;
        end
        // Final write is on the bus during DRAIN; close the transfer.
        DRAIN: begin
          DST_WE <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign DST_DATA = (mode_q == MODE_FILL) ? fill_q : SRC_Q;
  assign DST_CEN  = cen;

endmodule

// File: tb/tb_sram_block_copier.sv
module tb_sram_block_copier;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int N  = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_base, dst_base;
  logic [AW:0]   len;
  logic [DW-1:0] fill_value;
  logic          busy, done, DST_WE, DST_CEN;
  logic [AW-1:0] SRC_ADDR, DST_ADDR;
  logic [DW-1:0] SRC_Q, DST_DATA;

  sram_block_copier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .len(len), .fill_value(fill_value),
    .busy(busy), .done(done), .SRC_ADDR(SRC_ADDR), .SRC_Q(SRC_Q),
    .DST_ADDR(DST_ADDR), .DST_DATA(DST_DATA), .DST_WE(DST_WE), .DST_CEN(DST_CEN)
  );

  always #5 clk = ~clk;

  // Source and destination synchronous RAMs
  logic [DW-1:0] src_mem [N];
  logic [DW-1:0] dst_mem [N];
  int            wcount  [N];
  logic [DW-1:0] src_q;
  assign SRC_Q = src_q;

  always @(posedge clk) if (cen) src_q <= src_mem[SRC_ADDR];

  always @(posedge clk)
    if (DST_CEN && DST_WE) begin
      dst_mem[DST_ADDR] <= DST_DATA;
      wcount[DST_ADDR]  <= wcount[DST_ADDR] + 1;
    end

  initial for (int i = 0; i < N; i++) wcount[i] = 0;

  // Reference model: a transaction accepted in enabled cycle t0 fully
  // determines every output as a function of k = (enabled cycle) - t0.
  int   ecyc, t0, m_len, m_src, m_dst, acc_cnt, we_cnt;
  bit   have_t, m_mode;
  logic [DW-1:0] m_fill;

  function automatic bit model_idle();
    return !have_t || (ecyc - t0) >= ((m_len == 0) ? 2 : m_len + 3);
  endfunction

  initial begin acc_cnt = 0; we_cnt = 0; have_t = 0; ecyc = 0; t0 = 0; end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      have_t = 0;
      ecyc   = 0;
    end else if (cen) begin
      if (start && model_idle()) begin
        have_t = 1;
        t0     = ecyc;
        m_src  = int'(src_base);
        m_dst  = int'(dst_base);
        m_len  = int'(len);
        m_mode = mode;
        m_fill = fill_value;
        acc_cnt++;
      end
      if (DST_WE) we_cnt++;
      ecyc++;
    end
  end

  int errors = 0, checks = 0;
  int last_done_k = -1, done_cnt = 0, busy_cnt = 0;
  int cen_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    cen = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (cen_mode)
        0:       cen = 1'b1;
        1:       cen = ~cen;
        default: cen = ($urandom_range(0, 9) < 8);
      endcase
    end
  end

  task automatic go(input int s, input int d, input int l, input bit md, input int f);
    int a, n;
    @(posedge clk); #1;
    src_base = AW'(s); dst_base = AW'(d); len = (AW+1)'(l);
    mode = md; fill_value = DW'(f); start = 1'b1;
    a = acc_cnt; n = 0;
    while (acc_cnt == a && n < 200) begin @(posedge clk); #1; n++; end
    start = 1'b0;
    if (acc_cnt == a) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!model_idle() && n < budget) begin @(posedge clk); #1; n++; end
    if (!model_idle()) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_copy(input string name, input int s, input int d, input int l);
    int bad = 0;
    for (int i = 0; i < l; i++)
      if (dst_mem[(d + i) % N] !== src_mem[(s + i) % N]) bad++;
    chk(name, bad, 0);
  endtask

  int wc0 [N];
  int we0, dn0, bz0;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; src_base = '0; dst_base = '0;
    len = '0; fill_value = '0;
    for (int i = 0; i < N; i++) src_mem[i] = DW'($urandom);
    src_mem[16] = 8'hA1; src_mem[17] = 8'hB2; src_mem[18] = 8'hC3; src_mem[19] = 8'hD4;

    // Per-cycle compare against the model
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          int k;
          bit eb, ed, ew;
          k  = have_t ? ecyc - t0 : -100;
          eb = have_t && m_len > 0 && k >= 1 && k <= m_len + 1;
          ed = have_t && ((m_len == 0) ? (k == 1) : (k == m_len + 2));
          ew = have_t && m_len > 0 && k >= 2 && k <= m_len + 1;
          chk("busy", int'(busy), int'(eb));
          chk("done", int'(done), int'(ed));
          chk("dst_we", int'(DST_WE), int'(ew));
          chk("dst_cen", int'(DST_CEN), int'(cen));
          if (ew) begin
            chk("dst_addr", int'(DST_ADDR), (m_dst + k - 2) % N);
            chk("dst_data", int'(DST_DATA),
                int'(m_mode ? m_fill : src_mem[(m_src + k - 2) % N]));
          end
          if (eb && k <= m_len) chk("src_addr", int'(SRC_ADDR), (m_src + k - 1) % N);
          if (done) begin last_done_k = k; done_cnt++; end
          if (busy) busy_cnt++;
        end
      end
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(DST_WE), 0);
    chk("rst_src_addr", int'(SRC_ADDR), 0);
    chk("rst_dst_addr", int'(DST_ADDR), 0);
    #2 rst = 1'b0;

    // 1: basic copy
    we0 = we_cnt; dn0 = done_cnt;
    go(16, 'h200, 4, 1'b0, 0);
    wait_idle(100);
    chk("t1_d0", int'(dst_mem['h200]), 'hA1);
    chk("t1_d1", int'(dst_mem['h201]), 'hB2);
    chk("t1_d2", int'(dst_mem['h202]), 'hC3);
    chk("t1_d3", int'(dst_mem['h203]), 'hD4);
    chk("t1_we_cycles", we_cnt - we0, 4);
    chk("t1_done_k", last_done_k, 6);
    chk("t1_done_cnt", done_cnt - dn0, 1);

    // 2: fill with wrap-around
    go(int'($urandom_range(0, N-1)), 'h3FE, 4, 1'b1, 'h5A);
    wait_idle(100);
    chk("t2_3fe", int'(dst_mem['h3FE]), 'h5A);
    chk("t2_3ff", int'(dst_mem['h3FF]), 'h5A);
    chk("t2_000", int'(dst_mem['h000]), 'h5A);
    chk("t2_001", int'(dst_mem['h001]), 'h5A);

    // 3: zero length
    we0 = we_cnt; dn0 = done_cnt; bz0 = busy_cnt;
    go(5, 'h300, 0, 1'b0, 0);
    wait_idle(100);
    chk("t3_we_cycles", we_cnt - we0, 0);
    chk("t3_busy_seen", busy_cnt - bz0, 0);
    chk("t3_done_k", last_done_k, 1);
    chk("t3_done_cnt", done_cnt - dn0, 1);

    // 4: cen toggling every other cycle
    cen_mode = 1;
    we0 = we_cnt;
    go('h040, 'h080, 8, 1'b0, 0);
    wait_idle(200);
    chk_copy("t4_contents", 'h040, 'h080, 8);
    chk("t4_we_cycles", we_cnt - we0, 8);
    chk("t4_done_k", last_done_k, 10);
    cen_mode = 0;
    @(posedge clk); #1;

    // 5: reset in the middle of a copy
    wc0 = wcount;
    go('h020, 'h100, 16, 1'b0, 0);
    begin
      int n = 0;
      while ((ecyc - t0) != 5 && n < 50) begin @(posedge clk); #1; n++; end
    end
    chk("t5_we_before", int'(DST_WE), 1);
    chk("t5_addr_before", int'(DST_ADDR), 'h103);
    #2 rst = 1'b1;
    #1;
    chk("t5_we_in_rst", int'(DST_WE), 0);
    chk("t5_busy_in_rst", int'(busy), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 16; i++)
        if (wcount['h100 + i] - wc0['h100 + i] != ((i < 3) ? 1 : 0)) bad++;
      chk("t5_partial_writes", bad, 0);
    end
    go('h020, 'h100, 16, 1'b0, 0);
    wait_idle(100);
    chk_copy("t5_restart", 'h020, 'h100, 16);

    // 6: full-RAM copy with ignored re-starts while busy
    wc0 = wcount;
    go('h155, 'h2AA, N, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      src_base = 'h100; dst_base = 'h000; len = 3; mode = 1'b1; start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle(3000);
    chk_copy("t6_contents", 'h155, 'h2AA, N);
    begin
      int bad = 0;
      for (int i = 0; i < N; i++) if (wcount[i] - wc0[i] != 1) bad++;
      chk("t6_write_once", bad, 0);
    end

    // Randomized transfers under varying clock-enable patterns
    for (int t = 0; t < 30; t++) begin
      int s, d, l;
      bit md;
      int f;
      cen_mode = int'($urandom_range(0, 2));
      s  = int'($urandom_range(0, N-1));
      d  = int'($urandom_range(0, N-1));
      l  = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 60));
      md = 1'($urandom_range(0, 1));
      f  = int'($urandom_range(0, 255));
      go(s, d, l, md, f);
      wait_idle(1000);
      if (md) begin
        int bad = 0;
        for (int i = 0; i < l; i++) if (dst_mem[(d + i) % N] !== DW'(f)) bad++;
        chk("rand_fill", bad, 0);
      end else begin
        chk_copy("rand_copy", s, d, l);
      end
    end
    cen_mode = 0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
